// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: E0/F0 prefix FSM -> {ext,break,code} events in a FWFT FIFO, plus arrow-key hold state.
// Latency: an event is visible on evt_valid the cycle after the final scan-code strobe; arrows_held updates on the same edge.
// Backpressure: evt_valid/evt_ready handshake; pushes into a full FIFO without a pop are dropped and set sticky fifo_overflow.
// Optional build macro PS2DEC_TYPEMATIC_FILTER_EN suppresses auto-repeat makes that match the last pushed make.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_break,
    output logic       evt_ext,
    output logic [3:0] arrows_held,
    output logic [4:0] fifo_count,
    output logic       fifo_overflow
);
    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    state_t          state_q, state_d;
    evt_t            mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [4:0]      count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [3:0]      arrows_q, arrows_d;

    logic            emit, emit_ext, emit_brk;
    logic            is_e0, is_f0;
    logic [3:0]      arrow_sel;
    logic            push_req, push_ok, pop, full;
    evt_t            push_dat;

    assign is_e0    = (ps2_key_data == 8'hE0);
    assign is_f0    = (ps2_key_data == 8'hF0);
    assign push_dat = '{ext: emit_ext, brk: emit_brk, code: ps2_key_data};

    // Prefix FSM: next state and the event emitted by this strobe
    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        if (ps2_key_pressed) begin
            unique case (state_q)
                IDLE: begin
                    if (is_e0)      state_d = GOT_E0;
                    else if (is_f0) state_d = GOT_F0;
                    else            emit = 1'b1;
                end
                GOT_E0: begin
                    if (is_f0)      state_d = GOT_E0F0;
                    else if (is_e0) state_d = GOT_E0;
                    else begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = IDLE;
                    end
                end
                GOT_F0, GOT_E0F0: begin
                    // A prefix byte after F0 is a protocol error: drop the whole sequence.
                    state_d = IDLE;
                    if (!is_e0 && !is_f0) begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        emit_ext = (state_q == GOT_E0F0);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Arrow map {up,down,left,right}; only extended codes touch the held mask
    always_comb begin
        arrow_sel = 4'b0000;
        unique case (ps2_key_data)
            8'h75:   arrow_sel = 4'b1000;
            8'h72:   arrow_sel = 4'b0100;
            8'h6B:   arrow_sel = 4'b0010;
            8'h74:   arrow_sel = 4'b0001;
            default: arrow_sel = 4'b0000;
        endcase
        arrows_d = arrows_q;
        if (emit && emit_ext) begin
            if (emit_brk) arrows_d = arrows_q & ~arrow_sel;
            else          arrows_d = arrows_q | arrow_sel;
        end
    end

`ifdef PS2DEC_TYPEMATIC_FILTER_EN
    logic [8:0] rec_q, rec_d;
    logic       rec_vld_q, rec_vld_d;
    logic       rec_hit;

    assign rec_hit  = rec_vld_q && (rec_q == {emit_ext, ps2_key_data});
    assign push_req = emit && !(rec_hit && !emit_brk);

    // Track the last make that actually entered the FIFO; its matching break re-arms it
    always_comb begin
        rec_d     = rec_q;
        rec_vld_d = rec_vld_q;
        if (push_ok && !emit_brk) begin
            rec_d     = {emit_ext, ps2_key_data};
            rec_vld_d = 1'b1;
        end else if (emit && emit_brk && rec_hit) begin
            rec_vld_d = 1'b0;
        end
    end

    // Filter record registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rec_q     <= '0;
            rec_vld_q <= 1'b0;
        end else begin
            rec_q     <= rec_d;
            rec_vld_q <= rec_vld_d;
        end
    end
`else
    assign push_req = emit;
`endif

    assign full    = (count_q == DEPTH_C);
    assign pop     = (count_q != 5'd0) && evt_ready;
    assign push_ok = push_req && (!full || pop);

    // Occupancy and sticky overflow; a pop frees the slot for a same-cycle push even when full
    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q | (push_req && full && !pop);
    end

    // State, FIFO storage/pointers and held-arrow registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            arrows_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            arrows_q   <= arrows_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    assign evt_valid     = (count_q != 5'd0);
    assign evt_code      = mem_q[rd_ptr_q].code;
    assign evt_break     = mem_q[rd_ptr_q].brk;
    assign evt_ext       = mem_q[rd_ptr_q].ext;
    assign arrows_held   = arrows_q;
    assign fifo_count    = count_q;
    assign fifo_overflow = overflow_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed vector table, hand-written corner sequences, random run vs a queue model.
// Inputs change just after the falling edge; outputs are sampled on the next falling edge.
// Build with PS2DEC_TYPEMATIC_FILTER_EN defined or not; expectations follow the same macro.
module tb_ps2_key_decoder;
    localparam int DEPTH = 8;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] ps2_key_data = 8'h00;
    logic       ps2_key_pressed = 1'b0;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic [3:0] arrows_held;
    logic [4:0] fifo_count;
    logic       fifo_overflow;

    int errors = 0;
    int checks = 0;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .resetn(resetn),
        .ps2_key_data(ps2_key_data), .ps2_key_pressed(ps2_key_pressed),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_break(evt_break), .evt_ext(evt_ext),
        .arrows_held(arrows_held), .fifo_count(fifo_count), .fifo_overflow(fifo_overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         p;
        logic [7:0] d;
        bit         r;
        bit         v;
        logic [9:0] head;   // {ext, break, code}
        logic [3:0] arr;
        logic [4:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit p, logic [7:0] d, bit r, bit v, logic [9:0] h, logic [3:0] a, logic [4:0] c);
        vec_t x;
        x.p = p; x.d = d; x.r = r; x.v = v; x.head = h; x.arr = a; x.cnt = c;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge) and return at the next falling edge
    task automatic cyc(input bit p, input logic [7:0] d, input bit r);
        ps2_key_pressed = p;
        ps2_key_data    = d;
        evt_ready       = r;
        @(negedge clock);
        ps2_key_pressed = 1'b0;
    endtask

    task automatic do_reset();
        ps2_key_pressed = 1'b0;
        evt_ready       = 1'b0;
        resetn          = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    function automatic logic [9:0] head();
        return {evt_ext, evt_break, evt_code};
    endfunction

    // ---------------- behavioural model ----------------
    logic [9:0] mq[$];
    bit         m_e0, m_f0, m_ovf;
    logic [3:0] m_arr;
    bit         m_rec_vld;
    logic [8:0] m_rec;

    function automatic int arrow_idx(logic [7:0] c);
        case (c)
            8'h75:   return 3;
            8'h72:   return 2;
            8'h6B:   return 1;
            8'h74:   return 0;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_e0 = 0; m_f0 = 0; m_ovf = 0; m_arr = 4'b0; m_rec_vld = 0; m_rec = '0;
    endtask

    // Effect of one rising edge given the inputs held during that cycle
    task automatic model_step(input bit p, input logic [7:0] d, input bit r);
        bit emit = 0, ext = 0, brk = 0, want = 0;
        bit do_pop;
        int n_before, ai;
        n_before = mq.size();
        do_pop   = (n_before > 0) && r;
        if (p) begin
            if (d == 8'hE0) begin
                if (m_f0) begin m_e0 = 0; m_f0 = 0; end else m_e0 = 1;
            end else if (d == 8'hF0) begin
                if (m_f0) begin m_e0 = 0; m_f0 = 0; end else m_f0 = 1;
            end else begin
                emit = 1; ext = m_e0; brk = m_f0;
                m_e0 = 0; m_f0 = 0;
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (emit) begin
            ai = arrow_idx(d);
            if (ext && ai >= 0) m_arr[ai] = !brk;
            want = 1;
`ifdef PS2DEC_TYPEMATIC_FILTER_EN
            if (m_rec_vld && m_rec == {ext, d}) begin
                if (brk) m_rec_vld = 0;
                else     want = 0;
            end
`endif
            if (want) begin
                if (n_before == DEPTH && !do_pop) m_ovf = 1;
                else begin
                    mq.push_back({ext, brk, d});
                    if (!brk) begin m_rec_vld = 1; m_rec = {ext, d}; end
                end
            end
        end
    endtask

    logic [7:0] pick_tbl [10];

    initial begin
        int exp_n;
        pick_tbl = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C, 8'h00};

        // ---------------- reset state ----------------
        do_reset();
        check("rst_valid",    32'(evt_valid), 0);
        check("rst_count",    32'(fifo_count), 0);
        check("rst_overflow", 32'(fifo_overflow), 0);
        check("rst_arrows",   32'(arrows_held), 0);
        check("rst_head",     32'(head()), 0);

        // ---------------- directed vector table ----------------
        tbl.push_back(mk(1, 8'h1C, 1, 1, 10'h01C, 4'h0, 5'd1));
        tbl.push_back(mk(1, 8'hF0, 1, 0, 10'h000, 4'h0, 5'd0));
        tbl.push_back(mk(1, 8'h1C, 1, 1, 10'h11C, 4'h0, 5'd1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 10'h000, 4'h0, 5'd0));
        tbl.push_back(mk(1, 8'hE0, 0, 0, 10'h000, 4'h0, 5'd0));
        tbl.push_back(mk(1, 8'h75, 0, 1, 10'h275, 4'h8, 5'd1));
        tbl.push_back(mk(1, 8'hE0, 0, 1, 10'h275, 4'h8, 5'd1));
        tbl.push_back(mk(1, 8'hF0, 0, 1, 10'h275, 4'h8, 5'd1));
        tbl.push_back(mk(1, 8'h75, 0, 1, 10'h275, 4'h0, 5'd2));
        tbl.push_back(mk(0, 8'h00, 1, 1, 10'h375, 4'h0, 5'd1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 10'h000, 4'h0, 5'd0));
        tbl.push_back(mk(1, 8'hF0, 1, 0, 10'h000, 4'h0, 5'd0));
        tbl.push_back(mk(1, 8'hE0, 1, 0, 10'h000, 4'h0, 5'd0));
        tbl.push_back(mk(1, 8'h1C, 0, 1, 10'h01C, 4'h0, 5'd1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 10'h000, 4'h0, 5'd0));
        tbl.push_back(mk(1, 8'hE0, 0, 0, 10'h000, 4'h0, 5'd0));
        tbl.push_back(mk(1, 8'hE0, 0, 0, 10'h000, 4'h0, 5'd0));
        tbl.push_back(mk(1, 8'h74, 0, 1, 10'h274, 4'h1, 5'd1));
        tbl.push_back(mk(1, 8'hE0, 0, 1, 10'h274, 4'h1, 5'd1));
        tbl.push_back(mk(1, 8'hF0, 0, 1, 10'h274, 4'h1, 5'd1));
        tbl.push_back(mk(1, 8'h74, 0, 1, 10'h274, 4'h0, 5'd2));
        tbl.push_back(mk(0, 8'h00, 1, 1, 10'h374, 4'h0, 5'd1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 10'h000, 4'h0, 5'd0));
        tbl.push_back(mk(1, 8'hE0, 0, 0, 10'h000, 4'h0, 5'd0));
        tbl.push_back(mk(1, 8'h6B, 0, 1, 10'h26B, 4'h2, 5'd1));
        tbl.push_back(mk(1, 8'hE0, 0, 1, 10'h26B, 4'h2, 5'd1));
        tbl.push_back(mk(1, 8'h72, 0, 1, 10'h26B, 4'h6, 5'd2));
        tbl.push_back(mk(0, 8'h00, 1, 1, 10'h272, 4'h6, 5'd1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 10'h000, 4'h6, 5'd0));
        foreach (tbl[i]) begin
            cyc(tbl[i].p, tbl[i].d, tbl[i].r);
            check($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(tbl[i].v));
            check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
            check($sformatf("vec%0d_arrows", i), 32'(arrows_held), 32'(tbl[i].arr));
            if (tbl[i].v) check($sformatf("vec%0d_head", i), 32'(head()), 32'(tbl[i].head));
        end

        // ---------------- overflow: 9 makes into a stalled FIFO ----------------
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(1, 8'h10 + 8'(i), 0);
            if (i == 7) check("ovf_before_drop", 32'(fifo_overflow), 0);
        end
        check("ovf_count",    32'(fifo_count), 8);
        check("ovf_flag",     32'(fifo_overflow), 1);
        check("ovf_head",     32'(head()), 32'h010);
        cyc(0, 8'h00, 0);
        check("ovf_sticky",   32'(fifo_overflow), 1);

        // ---------------- full FIFO with simultaneous push and pop ----------------
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 8'h30 + 8'(i), 0);
        check("full_count", 32'(fifo_count), 8);
        cyc(1, 8'h40, 1);
        check("pushpop_count",    32'(fifo_count), 8);
        check("pushpop_overflow", 32'(fifo_overflow), 0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] want_code;
            want_code = (i < 7) ? 8'h31 + 8'(i) : 8'h40;
            check($sformatf("drain%0d_head", i), 32'(head()), 32'({2'b00, want_code}));
            cyc(0, 8'h00, 1);
        end
        check("drain_empty", 32'(evt_valid), 0);

        // ---------------- typematic repeats ----------------
        do_reset();
        cyc(1, 8'h1C, 0); cyc(1, 8'h1C, 0); cyc(1, 8'h1C, 0);
        cyc(1, 8'hF0, 0); cyc(1, 8'h1C, 0);
`ifdef PS2DEC_TYPEMATIC_FILTER_EN
        exp_n = 2;
`else
        exp_n = 4;
`endif
        check("typematic_count", 32'(fifo_count), 32'(exp_n));
        check("typematic_head",  32'(head()), 32'h01C);

        // ---------------- reset in the middle of a prefix sequence ----------------
        do_reset();
        cyc(1, 8'hE0, 0); cyc(1, 8'h75, 0);
        check("pre_rst_arrows", 32'(arrows_held), 32'h8);
        cyc(1, 8'hE0, 0);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_count",  32'(fifo_count), 0);
        check("async_rst_arrows", 32'(arrows_held), 0);
        check("async_rst_head",   32'(head()), 0);
        @(negedge clock);
        resetn = 1'b1;
        cyc(1, 8'h75, 1);
        check("post_rst_valid",  32'(evt_valid), 1);
        check("post_rst_head",   32'(head()), 32'h075);
        check("post_rst_arrows", 32'(arrows_held), 0);

        // ---------------- random run against the model ----------------
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            bit         p, r;
            logic [7:0] d;
            int         k;
            p = ($urandom_range(0, 1) == 1);
            k = $urandom_range(0, 9);
            d = (k == 9) ? 8'($urandom) : pick_tbl[k];
            r = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            model_step(p, d, r);
            cyc(p, d, r);
            check("rnd_count",  32'(fifo_count), 32'(mq.size()));
            check("rnd_status", 32'({fifo_overflow, arrows_held}), 32'({m_ovf, m_arr}));
            if (mq.size() > 0) check("rnd_head", 32'(head()), 32'(mq[0]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
